// File: rtl/i2c_target_rx.sv
// ----------------------------------------------------------------------------
// i2c_target_rx
//
// Write-only I2C target receiver. Oversamples SCL/SDA with clk, detects
// START/STOP, matches a 7-bit address with R/W=0, ACKs the address and every
// data byte by pulling SDA low through an open-drain enable, and hands each
// completed data byte downstream as a one-clk strobe. SCL is never driven.
//
// Ports
//   clk         in   system clock (>= 8x SCL, SCL phases >= 4 clk)
//   reset_n     in   asynchronous active-low reset
//   i2c_scl     in   raw bus SCL
//   i2c_sda_in  in   raw bus SDA
//   i2c_sda_oe  out  1 = pull SDA low (ACK), 0 = release
//   rx_data     out  last received data byte (MSB first on the bus)
//   rx_valid    out  one-clk pulse when rx_data updates
//   addr_match  out  high from address ACK until next STOP/START
//   stop_det    out  one-clk pulse on every STOP
//   busy        out  high from START until STOP
//
// States
//   IDLE     | bus free, waiting for START
//   ADDR     | shifting in address + R/W
//   ACK_ADDR | driving ACK for the address byte
//   DATA     | shifting in a data byte
//   ACK_DATA | driving ACK for a data byte
//   IGNORE   | not addressed (or read request), wait for START/STOP
// ----------------------------------------------------------------------------
module i2c_target_rx #(
    parameter logic [6:0] ADDRESS = 7'h50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i2c_scl,
    input  logic       i2c_sda_in,
    output logic       i2c_sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       addr_match,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ACK_ADDR = 3'd2,
        DATA     = 3'd3,
        ACK_DATA = 3'd4,
        IGNORE   = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning. Flops reset to 1 (idle bus level) so that
    // releasing reset on an idle bus cannot fake a START or SCL edge.
    // ------------------------------------------------------------------
    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= i2c_scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= i2c_sda_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    logic ev_start, ev_stop, ev_scl_rise, ev_scl_fall;

    always_comb begin
        ev_start    = scl_s2 &  sda_d & ~sda_s2;
        ev_stop     = scl_s2 & ~sda_d &  sda_s2;
        ev_scl_rise =  scl_s2 & ~scl_d;
        ev_scl_fall = ~scl_s2 &  scl_d;
    end

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t     state_q,      state_n;
    logic [3:0] bit_cnt_q,    bit_cnt_n;
    logic [6:0] shift_q,      shift_n;
    logic       sda_oe_q,     sda_oe_n;
    logic       addr_match_q, addr_match_n;
    logic       busy_q,       busy_n;
    logic [7:0] rx_data_q,    rx_data_n;
    logic       rx_valid_q,   rx_valid_n;
    logic       stop_det_q,   stop_det_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 7'd0;
            sda_oe_q     <= 1'b0;
            addr_match_q <= 1'b0;
            busy_q       <= 1'b0;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            stop_det_q   <= 1'b0;
        end else begin
            state_q      <= state_n;
            bit_cnt_q    <= bit_cnt_n;
            shift_q      <= shift_n;
            sda_oe_q     <= sda_oe_n;
            addr_match_q <= addr_match_n;
            busy_q       <= busy_n;
            rx_data_q    <= rx_data_n;
            rx_valid_q   <= rx_valid_n;
            stop_det_q   <= stop_det_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    logic [3:0] bit_cnt_inc;
    logic [7:0] byte_in;
    logic       byte_done;

    always_comb begin
        bit_cnt_inc = bit_cnt_q + 4'd1;
        byte_in     = {shift_q, sda_s2};
        byte_done   = (bit_cnt_inc == 4'd8);
    end

    always_comb begin
        state_n      = state_q;
        bit_cnt_n    = bit_cnt_q;
        shift_n      = shift_q;
        sda_oe_n     = sda_oe_q;
        addr_match_n = addr_match_q;
        busy_n       = busy_q;
        rx_data_n    = rx_data_q;
        rx_valid_n   = 1'b0;
        stop_det_n   = 1'b0;

        if (ev_stop) begin
            state_n      = IDLE;
            sda_oe_n     = 1'b0;
            addr_match_n = 1'b0;
            busy_n       = 1'b0;
            stop_det_n   = 1'b1;
        end else if (ev_start) begin
            // Covers both a fresh START and a repeated START; any partial
            // byte in the shifter is simply abandoned.
            state_n      = ADDR;
            bit_cnt_n    = 4'd0;
            sda_oe_n     = 1'b0;
            addr_match_n = 1'b0;
            busy_n       = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_oe_n = 1'b0;
                end

                ADDR: begin
                    if (ev_scl_rise) begin
                        shift_n   = byte_in[6:0];
                        bit_cnt_n = bit_cnt_inc;
                        if (byte_done) begin
                            bit_cnt_n = 4'd0;
                            if (byte_in[7:1] == ADDRESS && !byte_in[0])
                                state_n = ACK_ADDR;
                            else
                                state_n = IGNORE;
                        end
                    end
                end

                // First SCL fall (end of bit 8) starts the ACK; second fall
                // (end of the ACK clock) releases SDA. sda_oe itself tells
                // which of the two falls this is.
                ACK_ADDR, ACK_DATA: begin
                    if (ev_scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_n = 1'b1;
                            if (state_q == ACK_ADDR)
                                addr_match_n = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 4'd0;
                            state_n   = DATA;
                        end
                    end
                end

                DATA: begin
                    if (ev_scl_rise) begin
                        shift_n   = byte_in[6:0];
                        bit_cnt_n = bit_cnt_inc;
                        if (byte_done) begin
                            bit_cnt_n  = 4'd0;
                            rx_data_n  = byte_in;
                            rx_valid_n = 1'b1;
                            state_n    = ACK_DATA;
                        end
                    end
                end

                IGNORE: begin
                    sda_oe_n = 1'b0;
                end

                default: begin
                    state_n  = IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        i2c_sda_oe = sda_oe_q;
        rx_data    = rx_data_q;
        rx_valid   = rx_valid_q;
        addr_match = addr_match_q;
        stop_det   = stop_det_q;
        busy       = busy_q;
    end

endmodule

// File: tb/tb_i2c_target_rx.sv
// ----------------------------------------------------------------------------
// tb_i2c_target_rx
//
// Directed bench for i2c_target_rx. A bit-banged bus master drives SCL and an
// open-drain SDA; expected data bytes go into a scoreboard queue as they are
// sent and are popped when rx_valid strobes. Side counters track ACK pulses,
// rx_valid pulses and stop_det pulses per transaction.
// ----------------------------------------------------------------------------
module tb_i2c_target_rx;

    logic       clk;
    logic       reset_n;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       i2c_sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       addr_match;
    logic       stop_det;
    logic       busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    int ack_cnt = 0;
    int rx_cnt = 0;
    int stop_cnt = 0;
    logic oe_prev = 1'b0;
    logic valid_prev = 1'b0;

    assign sda_bus = sda_m & ~i2c_sda_oe;

    i2c_target_rx #(.ADDRESS(7'h50)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i2c_scl    (scl),
        .i2c_sda_in (sda_bus),
        .i2c_sda_oe (i2c_sda_oe),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .addr_match (addr_match),
        .stop_det   (stop_det),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endfunction

    // Monitor: scoreboard pop on rx_valid plus pulse counters.
    always @(negedge clk) begin
        if (reset_n) begin
            if (i2c_sda_oe && !oe_prev) ack_cnt++;
            if (stop_det) stop_cnt++;
            if (rx_valid) begin
                rx_cnt++;
                check("rx_valid_width", {31'd0, valid_prev}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
        oe_prev    = i2c_sda_oe;
        valid_prev = rx_valid;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        wait_clk(4); sda_m = 1'b1;
        wait_clk(4); scl = 1'b1;
        wait_clk(4); sda_m = 1'b0;
        wait_clk(6); scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(4); sda_m = 1'b0;
        wait_clk(4); scl = 1'b1;
        wait_clk(4); sda_m = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_bit(input logic b);
        wait_clk(4); sda_m = b;
        wait_clk(4); scl = 1'b1;
        wait_clk(8); scl = 1'b0;
    endtask

    // Sends 8 bits plus an ACK clock; checks sda_oe is at exp_ack on every
    // sample of the 9th SCL high phase.
    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input logic push);
        int held;
        if (push) exp_q.push_back(b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        wait_clk(4); sda_m = 1'b1;
        wait_clk(4); scl = 1'b1;
        held = 0;
        repeat (8) begin
            @(negedge clk);
            if (i2c_sda_oe === exp_ack) held++;
        end
        scl = 1'b0;
        check("ack_hold", held, 8);
    endtask

    int a0, r0, s0;
    task automatic snap();
        a0 = ack_cnt; r0 = rx_cnt; s0 = stop_cnt;
    endtask

    task automatic check_counts(input string tag, input int acks, input int rxs);
        check({tag, "_acks"}, ack_cnt - a0, acks);
        check({tag, "_rx"},   rx_cnt - r0,  rxs);
        check({tag, "_stop"}, stop_cnt - s0, 1);
        check({tag, "_busy"}, {31'd0, busy}, 0);
        check({tag, "_match"}, {31'd0, addr_match}, 0);
    endtask

    initial begin
        int waited;
        scl = 1'b1; sda_m = 1'b1; reset_n = 1'b0;
        wait_clk(3);
        check("rst_oe",    {31'd0, i2c_sda_oe}, 0);
        check("rst_data",  {24'd0, rx_data}, 0);
        check("rst_valid", {31'd0, rx_valid}, 0);
        check("rst_match", {31'd0, addr_match}, 0);
        check("rst_stop",  {31'd0, stop_det}, 0);
        check("rst_busy",  {31'd0, busy}, 0);
        reset_n = 1'b1;
        wait_clk(5);

        // T1: 0x50+W, 0xAA
        snap();
        bus_start();
        check("t1_busy", {31'd0, busy}, 1);
        send_byte(8'hA0, 1'b1, 1'b0);
        check("t1_match", {31'd0, addr_match}, 1);
        send_byte(8'hAA, 1'b1, 1'b1);
        check("t1_match_data", {31'd0, addr_match}, 1);
        bus_stop();
        check_counts("t1", 2, 1);
        check("t1_rx_data", {24'd0, rx_data}, 32'hAA);

        // T2: wrong address 0x51
        snap();
        bus_start();
        send_byte(8'hA2, 1'b0, 1'b0);
        check("t2_match", {31'd0, addr_match}, 0);
        send_byte(8'hAA, 1'b0, 1'b0);
        bus_stop();
        check_counts("t2", 0, 0);

        // T3: read request NACKed
        snap();
        bus_start();
        send_byte(8'hA1, 1'b0, 1'b0);
        check("t3_match", {31'd0, addr_match}, 0);
        bus_stop();
        check_counts("t3", 0, 0);

        // T4: three bytes
        snap();
        bus_start();
        send_byte(8'hA0, 1'b1, 1'b0);
        send_byte(8'h12, 1'b1, 1'b1);
        send_byte(8'h34, 1'b1, 1'b1);
        send_byte(8'hFF, 1'b1, 1'b1);
        bus_stop();
        check_counts("t4", 4, 3);

        // T5: partial byte then repeated START
        snap();
        bus_start();
        send_byte(8'hA0, 1'b1, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bus_start();
        check("t5_busy_rs", {31'd0, busy}, 1);
        check("t5_match_rs", {31'd0, addr_match}, 0);
        send_byte(8'hA0, 1'b1, 1'b0);
        send_byte(8'h5A, 1'b1, 1'b1);
        bus_stop();
        check_counts("t5", 3, 1);
        check("t5_rx_data", {24'd0, rx_data}, 32'h5A);

        // T6: reset while ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 5 || i == 7);
        wait_clk(4); sda_m = 1'b1;
        waited = 0;
        while (i2c_sda_oe !== 1'b1 && waited < 20) begin
            wait_clk(1);
            waited++;
        end
        check("t6_oe_seen", {31'd0, i2c_sda_oe}, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_oe",    {31'd0, i2c_sda_oe}, 0);
        check("t6_rst_data",  {24'd0, rx_data}, 0);
        check("t6_rst_match", {31'd0, addr_match}, 0);
        check("t6_rst_busy",  {31'd0, busy}, 0);
        check("t6_rst_valid", {31'd0, rx_valid}, 0);
        check("t6_rst_stop",  {31'd0, stop_det}, 0);
        wait_clk(4); scl = 1'b1;
        wait_clk(6); reset_n = 1'b1;
        wait_clk(6);

        // T7: normal transaction after reset
        snap();
        bus_start();
        send_byte(8'hA0, 1'b1, 1'b0);
        send_byte(8'h3C, 1'b1, 1'b1);
        bus_stop();
        check_counts("t7", 2, 1);
        check("t7_rx_data", {24'd0, rx_data}, 32'h3C);
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
